jtcontra_snd_mailbox: RTL



---
 rtl/jtcontra_snd_mailbox.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jtcontra_snd_mailbox.sv
// Main-CPU to sound-CPU command mailbox: FIFO, selectable IRQ mode, sticky overflow.
// Optional sound-to-main reply latch enabled by JTCONTRA_MAILBOX_REPLY_EN.
module jtcontra_snd_mailbox #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 2,
  parameter int unsigned IRQ_MODE = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_main_we,
  input  logic [DW-1:0] i_main_din,
  output logic          o_main_full,
  output logic          o_ovf,
  input  logic          i_ovf_clr,
  input  logic          i_snd_cen,
  input  logic          i_snd_rd,
  input  logic          i_snd_ack,
  output logic [DW-1:0] o_snd_dout,
  output logic          o_snd_irq_n,
`ifdef JTCONTRA_MAILBOX_REPLY_EN
  input  logic          i_snd_we,
  input  logic [DW-1:0] i_snd_din,
  input  logic          i_main_rd,
  output logic [DW-1:0] o_main_reply,
  output logic          o_reply_valid,
`endif
  output logic [AW:0]   o_snd_level
);

  localparam int unsigned DEPTH    = 2**AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_full, r_ovf, r_flag, r_rearm, r_irq_n;
  logic [DW-1:0] r_held;

  logic          w_empty, w_pop, w_push, w_drop, w_ack;
  logic          w_flag_nxt, w_rearm_nxt, w_irq_n_nxt;
  logic [AW:0]   w_level_nxt;

  // Handshake decode and IRQ next-state; push beats ack, ack beats re-arm
  always_comb begin
    w_empty     = (r_level == '0);
    w_pop       = i_snd_rd & i_snd_cen & ~w_empty;
    w_push      = i_main_we & (~r_full | w_pop);
    w_drop      = i_main_we & ~w_push;
    w_ack       = i_snd_ack & i_snd_cen;
    w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_flag_nxt  = r_flag;
    w_rearm_nxt = 1'b0;
    if (w_push) begin
      w_flag_nxt = 1'b1;
    end else if (w_ack) begin
      w_flag_nxt  = 1'b0;
      w_rearm_nxt = (w_level_nxt != '0);
    end else if (r_rearm) begin
      w_flag_nxt = 1'b1;
    end
    if (IRQ_MODE == 0) w_irq_n_nxt = (w_level_nxt == '0);
    else               w_irq_n_nxt = ~w_flag_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_main_din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_flag   <= 1'b0;
      r_rearm  <= 1'b0;
      r_irq_n  <= 1'b1;
      r_held   <= '1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_held   <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
      r_flag  <= w_flag_nxt;
      r_rearm <= w_rearm_nxt;
      r_irq_n <= w_irq_n_nxt;
    end
  end

`ifdef JTCONTRA_MAILBOX_REPLY_EN
  logic [DW-1:0] r_reply;
  logic          r_reply_valid;

  // Reply latch: a load always overwrites and wins over the main-side clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_reply       <= '0;
      r_reply_valid <= 1'b0;
    end else if (i_snd_we & i_snd_cen) begin
      r_reply       <= i_snd_din;
      r_reply_valid <= 1'b1;
    end else if (i_main_rd) begin
      r_reply_valid <= 1'b0;
    end
  end

  assign o_main_reply  = r_reply;
  assign o_reply_valid = r_reply_valid;
`endif

  // Empty FIFO returns the last popped command (all-ones after reset)
  assign o_snd_dout  = w_empty ? r_held : r_mem[r_rd_ptr];
  assign o_main_full = r_full;
  assign o_ovf       = r_ovf;
  assign o_snd_irq_n = r_irq_n;
  assign o_snd_level = r_level;

endmodule
